// File: rtl/sram_port_arbiter.sv
// Two-port burst arbiter in front of a single-port SRAM macro (1-cycle read latency, active-low controls).
// Round-robin at burst granularity; read data returned with valid/ready and a skid hold register.
module sram_port_arbiter #(
    parameter int AW    = 14,
    parameter int DW    = 32,
    parameter int LEN_W = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic [1:0]           req_valid,
    input  logic [1:0]           req_write,
    input  logic [63:0]          req_addr,
    input  logic [2*LEN_W-1:0]   req_len,
    output logic [1:0]           req_ready,
    input  logic [2*DW-1:0]      wdata,
    input  logic [2*DW/8-1:0]    wstrb,
    input  logic [1:0]           wvalid,
    output logic [1:0]           wready,
    output logic [2*DW-1:0]      rdata,
    output logic [1:0]           rvalid,
    output logic [1:0]           rlast,
    input  logic [1:0]           rready,
    output logic                 sram_ceb,
    output logic                 sram_web,
    output logic [AW-1:0]        sram_a,
    output logic [DW-1:0]        sram_d,
    output logic [DW-1:0]        sram_bweb,
    input  logic [DW-1:0]        sram_q
);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             owner_q, owner_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0] rbeat_q, rbeat_d;
    logic             rvalid_q, rvalid_d;
    logic             fresh_q, fresh_d;
    logic [DW-1:0]    hold_q, hold_d;

    logic             win;
    logic             issue;
    logic             own_wvalid, own_rready;
    logic [DW-1:0]    own_wdata;
    logic [DW/8-1:0]  own_wstrb;
    logic [DW-1:0]    rd_cur;
    logic             unused_addr_bits;

    assign own_wvalid = owner_q ? wvalid[1] : wvalid[0];
    assign own_rready = owner_q ? rready[1] : rready[0];
    assign own_wdata  = owner_q ? wdata[2*DW-1:DW] : wdata[DW-1:0];
    assign own_wstrb  = owner_q ? wstrb[2*DW/8-1:DW/8] : wstrb[DW/8-1:0];
    // sram_q is only valid the cycle after an issue; later cycles of a stalled beat use the hold copy
    assign rd_cur     = fresh_q ? sram_q : hold_q;
    assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:AW+2], req_addr[33:32], req_addr[63:AW+34]};

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        rbeat_d   = rbeat_q;
        rvalid_d  = 1'b0;
        fresh_d   = 1'b0;
        hold_d    = fresh_q ? sram_q : hold_q;
        win       = 1'b0;
        issue     = 1'b0;
        req_ready = '0;
        wready    = '0;
        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_a    = '0;
        sram_d    = '0;
        sram_bweb = '1;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    win       = (&req_valid) ? rr_q : req_valid[1];
                    req_ready = win ? 2'b10 : 2'b01;
                    owner_d   = win;
                    rr_d      = ~win;
                    addr_d    = win ? req_addr[AW+33:34] : req_addr[AW+1:2];
                    len_d     = win ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
                    cnt_d     = '0;
                    rbeat_d   = '0;
                    state_d   = (win ? req_write[1] : req_write[0]) ? WR : RD;
                end
            end
            WR: begin
                wready = owner_q ? 2'b10 : 2'b01;
                if (own_wvalid) begin
                    sram_ceb = 1'b0;
                    sram_web = 1'b0;
                    sram_a   = addr_q;
                    sram_d   = own_wdata;
                    for (int unsigned b = 0; b < DW/8; b++) begin
                        sram_bweb[b*8 +: 8] = {8{~own_wstrb[b]}};
                    end
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == {1'b0, len_q}) begin
                        state_d = IDLE;
                    end
                end
            end
            RD: begin
                issue = (cnt_q <= {1'b0, len_q}) && (!rvalid_q || own_rready);
                if (issue) begin
                    sram_ceb = 1'b0;
                    sram_a   = addr_q;
                    addr_d   = addr_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
                fresh_d  = issue;
                rvalid_d = issue || (rvalid_q && !own_rready);
                if (rvalid_q && own_rready) begin
                    rbeat_d = rbeat_q + 1'b1;
                    if (rbeat_q == len_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rvalid = '0;
        rlast  = '0;
        rdata  = '0;
        if (rvalid_q) begin
            rvalid = owner_q ? 2'b10 : 2'b01;
            rlast  = (rbeat_q == len_q) ? rvalid : 2'b00;
            rdata  = owner_q ? {rd_cur, {DW{1'b0}}} : {{DW{1'b0}}, rd_cur};
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            rbeat_q  <= '0;
            rvalid_q <= 1'b0;
            fresh_q  <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            rbeat_q  <= rbeat_d;
            rvalid_q <= rvalid_d;
            fresh_q  <= fresh_d;
            hold_q   <= hold_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM whose output is garbage except
// in the cycle after a read access.
module tb_sram_port_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [1:0]  req_valid, req_write, req_ready;
    logic [63:0] req_addr;
    logic [7:0]  req_len;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic [1:0]  wvalid, wready, rvalid, rlast, rready;
    logic        sram_ceb, sram_web;
    logic [13:0] sram_a;
    logic [31:0] sram_d, sram_bweb, sram_q;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem  [0:16383];
    bit          wrtn [0:16383];
    logic [15:0] cyc = '0;

    always #5 ACLK = ~ACLK;

    sram_port_arbiter #(.AW(14), .DW(32), .LEN_W(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .req_ready(req_ready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
        .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a), .sram_d(sram_d),
        .sram_bweb(sram_bweb), .sram_q(sram_q)
    );

    function automatic logic [31:0] init_word(input logic [13:0] a);
        return {16'hC0DE, 2'b00, a};
    endfunction

    // Unwritten words read as C0DE_<addr>; q is scrambled on any cycle without a read
    always @(posedge ACLK) begin
        logic [31:0] base;
        cyc <= cyc + 1'b1;
        base = wrtn[sram_a] ? mem[sram_a] : init_word(sram_a);
        if (!sram_ceb && !sram_web) begin
            mem[sram_a]  <= (base & sram_bweb) | (sram_d & ~sram_bweb);
            wrtn[sram_a] <= 1'b1;
        end
        if (!sram_ceb && sram_web) sram_q <= base;
        else                        sram_q <= {16'hBAD0, cyc};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int p, input bit wr, input logic [31:0] addr, input logic [3:0] len);
        req_valid[p]          = 1'b1;
        req_write[p]          = wr;
        req_addr[p*32 +: 32]  = addr;
        req_len[p*4 +: 4]     = len;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 2'b00);
        chk({tag, "_wready"},    wready,    2'b00);
        chk({tag, "_rvalid"},    rvalid,    2'b00);
        chk({tag, "_rlast"},     rlast,     2'b00);
        chk({tag, "_ceb"},       sram_ceb,  1'b1);
        chk({tag, "_web"},       sram_web,  1'b1);
        chk({tag, "_bweb"},      sram_bweb, 32'hFFFF_FFFF);
    endtask

    logic [31:0] exp_rd [0:3];

    initial begin
        ARESETn = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
        wdata = '0; wstrb = '0; wvalid = '0; rready = '0;

        @(negedge ACLK); #1;
        chk_reset_vals("rst");
        @(negedge ACLK); ARESETn = 1'b1;
        @(negedge ACLK);

        // 1: single write, port 0
        req(0, 1'b1, 32'h10, 4'd0); #1;
        chk("t1_req_ready", req_ready, 2'b01);
        chk("t1_idle_ceb", sram_ceb, 1'b1);
        @(negedge ACLK);
        req_valid = '0; wvalid = 2'b01; wdata[31:0] = 32'hDEADBEEF; wstrb[3:0] = 4'hF; #1;
        chk("t1_wready", wready, 2'b01);
        chk("t1_req_ready_gap", req_ready, 2'b00);
        chk("t1_ceb", sram_ceb, 1'b0);
        chk("t1_web", sram_web, 1'b0);
        chk("t1_a", sram_a, 14'h4);
        chk("t1_d", sram_d, 32'hDEADBEEF);
        chk("t1_bweb", sram_bweb, 32'h0);
        @(negedge ACLK);
        wvalid = '0; #1;
        chk("t1_done_wready", wready, 2'b00);
        chk("t1_done_ceb", sram_ceb, 1'b1);

        // 2: read burst, port 1, full rready
        exp_rd[0] = 32'hDEADBEEF; exp_rd[1] = 32'hC0DE0005;
        exp_rd[2] = 32'hC0DE0006; exp_rd[3] = 32'hC0DE0007;
        @(negedge ACLK);
        req(1, 1'b0, 32'h10, 4'd3); rready = 2'b10; #1;
        chk("t2_req_ready", req_ready, 2'b10);
        @(negedge ACLK);
        req_valid = '0; #1;
        chk("t2_iss0_ceb", sram_ceb, 1'b0);
        chk("t2_iss0_web", sram_web, 1'b1);
        chk("t2_iss0_a", sram_a, 14'h4);
        chk("t2_iss0_rvalid", rvalid, 2'b00);
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK); #1;
            chk($sformatf("t2_b%0d_rvalid", k), rvalid, 2'b10);
            chk($sformatf("t2_b%0d_rdata", k), rdata[63:32], exp_rd[k]);
            chk($sformatf("t2_b%0d_rdata_p0", k), rdata[31:0], 32'h0);
            chk($sformatf("t2_b%0d_rlast", k), rlast, (k == 3) ? 2'b10 : 2'b00);
            chk($sformatf("t2_b%0d_ceb", k), sram_ceb, (k < 3) ? 1'b0 : 1'b1);
            if (k < 3) chk($sformatf("t2_b%0d_a", k), sram_a, 14'(5 + k));
        end
        @(negedge ACLK); #1;
        chk("t2_end_rvalid", rvalid, 2'b00);
        chk("t2_end_ceb", sram_ceb, 1'b1);

        // 3: same burst with rready low 3 cycles on beat 1
        @(negedge ACLK);
        req(1, 1'b0, 32'h10, 4'd3); rready = 2'b10; #1;
        chk("t3_req_ready", req_ready, 2'b10);
        @(negedge ACLK);
        req_valid = '0; #1;
        chk("t3_iss0_a", sram_a, 14'h4);
        @(negedge ACLK); #1;
        chk("t3_b0_rdata", rdata[63:32], 32'hDEADBEEF);
        chk("t3_b0_a", sram_a, 14'h5);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            rready = 2'b00; #1;
            chk($sformatf("t3_stall%0d_rvalid", k), rvalid, 2'b10);
            chk($sformatf("t3_stall%0d_rdata", k), rdata[63:32], 32'hC0DE0005);
            chk($sformatf("t3_stall%0d_ceb", k), sram_ceb, 1'b1);
        end
        @(negedge ACLK);
        rready = 2'b10; #1;
        chk("t3_b1_rdata", rdata[63:32], 32'hC0DE0005);
        chk("t3_b1_ceb", sram_ceb, 1'b0);
        chk("t3_b1_a", sram_a, 14'h6);
        @(negedge ACLK); #1;
        chk("t3_b2_rdata", rdata[63:32], 32'hC0DE0006);
        chk("t3_b2_a", sram_a, 14'h7);
        chk("t3_b2_rlast", rlast, 2'b00);
        @(negedge ACLK); #1;
        chk("t3_b3_rdata", rdata[63:32], 32'hC0DE0007);
        chk("t3_b3_rlast", rlast, 2'b10);
        chk("t3_b3_ceb", sram_ceb, 1'b1);
        @(negedge ACLK); #1;
        chk("t3_end_rvalid", rvalid, 2'b00);

        // 4: contention, both ports request writes every time
        @(negedge ACLK);
        rready = '0;
        req(0, 1'b1, 32'h100, 4'd0); req(1, 1'b1, 32'h200, 4'd0);
        wvalid = 2'b11; wdata = {32'hBBBB0000, 32'hAAAA0000}; wstrb = 8'hFF;
        for (int g = 0; g < 4; g++) begin
            if (g > 0) @(negedge ACLK);
            #1;
            chk($sformatf("t4_g%0d_grant", g), req_ready, (g % 2 == 1) ? 2'b10 : 2'b01);
            @(negedge ACLK);
            if (g == 3) req_valid = '0;
            #1;
            chk($sformatf("t4_g%0d_gap", g), req_ready, 2'b00);
            chk($sformatf("t4_g%0d_wready", g), wready, (g % 2 == 1) ? 2'b10 : 2'b01);
            chk($sformatf("t4_g%0d_a", g), sram_a, (g % 2 == 1) ? 14'h80 : 14'h40);
            chk($sformatf("t4_g%0d_d", g), sram_d, (g % 2 == 1) ? 32'hBBBB0000 : 32'hAAAA0000);
        end
        @(negedge ACLK);
        wvalid = '0; #1;
        chk("t4_end_req_ready", req_ready, 2'b00);

        // 5: partial strobes and word-address wrap
        @(negedge ACLK);
        wstrb = 8'h03; req(0, 1'b1, 32'hFFFC, 4'd1); #1;
        chk("t5_req_ready", req_ready, 2'b01);
        @(negedge ACLK);
        req_valid = '0; wvalid = 2'b01; wdata[31:0] = 32'h11223344; #1;
        chk("t5_b0_a", sram_a, 14'h3FFF);
        chk("t5_b0_bweb", sram_bweb, 32'hFFFF0000);
        chk("t5_b0_d", sram_d, 32'h11223344);
        chk("t5_b0_ceb", sram_ceb, 1'b0);
        @(negedge ACLK);
        wvalid = '0; #1;
        chk("t5_hold_ceb", sram_ceb, 1'b1);
        chk("t5_hold_wready", wready, 2'b01);
        @(negedge ACLK);
        wvalid = 2'b01; wdata[31:0] = 32'h55667788; #1;
        chk("t5_b1_a", sram_a, 14'h0);
        chk("t5_b1_bweb", sram_bweb, 32'hFFFF0000);
        chk("t5_b1_ceb", sram_ceb, 1'b0);
        @(negedge ACLK);
        wvalid = '0; #1;
        chk("t5_end_wready", wready, 2'b00);
        chk("t5_end_ceb", sram_ceb, 1'b1);

        // 6: reset during read beat 2, then a fresh burst
        @(negedge ACLK);
        req(0, 1'b0, 32'h0, 4'd3); rready = 2'b01; #1;
        chk("t6_req_ready", req_ready, 2'b01);
        @(negedge ACLK);
        req_valid = '0; #1;
        chk("t6_iss0_a", sram_a, 14'h0);
        @(negedge ACLK); #1;
        chk("t6_b0_rdata", rdata[31:0], 32'hC0DE7788);
        @(negedge ACLK); #1;
        chk("t6_b1_rdata", rdata[31:0], 32'hC0DE0001);
        @(negedge ACLK); #1;
        chk("t6_b2_rvalid", rvalid, 2'b01);
        chk("t6_b2_rdata", rdata[31:0], 32'hC0DE0002);
        ARESETn = 1'b0; #1;
        chk_reset_vals("t6_rst");
        @(negedge ACLK); #1;
        chk_reset_vals("t6_rst_next");
        ARESETn = 1'b1;
        @(negedge ACLK);
        req(0, 1'b1, 32'h20, 4'd0); req(1, 1'b1, 32'h40, 4'd0); #1;
        chk("t6_new_grant", req_ready, 2'b01);
        @(negedge ACLK);
        req_valid = '0; wvalid = 2'b01; wdata[31:0] = 32'h12345678; wstrb = 8'h0F; #1;
        chk("t6_new_ceb", sram_ceb, 1'b0);
        chk("t6_new_web", sram_web, 1'b0);
        chk("t6_new_a", sram_a, 14'h8);
        @(negedge ACLK);
        wvalid = '0; #1;
        chk("t6_new_end_ceb", sram_ceb, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
